// File: rtl/ham_15_11_encoder_stream_if.sv
// Streaming handshake bundle for the Hamming(15,11) encoder: data-word input side and
// codeword output side.
interface ham_15_11_encoder_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] d;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] cc;

    // master is the environment (word source and codeword sink); slave is the encoder
    modport master (
        output in_valid,
        output d,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  cc
    );

    modport slave (
        input  in_valid,
        input  d,
        input  out_ready,
        output in_ready,
        output out_valid,
        output cc
    );
endinterface

// File: rtl/ham_15_11_encoder_stream.sv
// Streaming Hamming(15,11) encoder: a word is encoded on accept into a small FIFO of
// codewords, and cc is driven from a registered copy of the queue head.
module ham_15_11_encoder_stream #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    ham_15_11_encoder_stream_if.slave      bus,
    output logic [15:0]                    word_count
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [14:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic [14:0]   head_q, head_d;
    logic [15:0]   word_count_q, word_count_d;
    logic [14:0]   enc;
    logic          accept;
    logic          deliver;

    // Codeword bit k is Hamming position k+1; parity sits at the power-of-two positions
    always_comb begin
        enc       = '0;
        enc[2]    = bus.d[0];
        enc[4]    = bus.d[1];
        enc[5]    = bus.d[2];
        enc[6]    = bus.d[3];
        enc[14:8] = bus.d[10:4];
        enc[0]    = ^{bus.d[0], bus.d[1], bus.d[3], bus.d[4], bus.d[6], bus.d[8], bus.d[10]};
        enc[1]    = ^{bus.d[0], bus.d[2], bus.d[3], bus.d[5], bus.d[6], bus.d[9], bus.d[10]};
        enc[3]    = ^{bus.d[1], bus.d[2], bus.d[3], bus.d[7], bus.d[8], bus.d[9], bus.d[10]};
        enc[7]    = ^bus.d[10:4];
    end

    assign accept  = bus.in_valid && ready_q;
    assign deliver = (count_q != '0) && bus.out_ready;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        word_count_d = word_count_q;
        head_d       = head_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (deliver) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            word_count_d = word_count_q + 16'd1;
        end
        unique case ({accept, deliver})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The next head may be the slot written this very cycle, so bypass the memory
        if (count_d != '0) begin
            if (accept && (wr_ptr_q == rd_ptr_d)) begin
                head_d = enc;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        ready_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= enc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            head_q       <= '0;
            word_count_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ready_q      <= ready_d;
            head_q       <= head_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.cc        = head_q;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_ham_15_11_encoder_stream.sv
// Bench for the streaming Hamming(15,11) encoder: constant vectors, corner-case sequences
// and a random stream checked against a queue-based model with an independent decoder.
module tb_ham_15_11_encoder_stream;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word_count;

    ham_15_11_encoder_stream_if bus ();

    ham_15_11_encoder_stream #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] d;
        logic [14:0] cc;
    } vec_t;

    vec_t        vecs [6];
    logic [10:0] q [$];
    logic [15:0] exp_wc = 16'd0;
    logic [15:0] wc_base;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Positions are 1..15; non-powers of two carry data in order, parity j covers bit j
    function automatic logic [14:0] ref_enc(input logic [10:0] dv);
        logic [14:0] c = '0;
        int          k = 0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = dv[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            logic par = 1'b0;
            for (int p = 1; p <= 15; p++) begin
                if (((p & (p - 1)) != 0) && p[j]) par ^= c[p-1];
            end
            c[(1 << j) - 1] = par;
        end
        return c;
    endfunction

    function automatic logic [10:0] ref_dec(input logic [14:0] cw);
        logic [14:0] c = cw;
        logic [10:0] dv = '0;
        int          s = 0;
        int          k = 0;
        for (int p = 1; p <= 15; p++) if (c[p-1]) s ^= p;
        if (s != 0) c[s-1] = ~c[s-1];
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                dv[k] = c[p-1];
                k++;
            end
        end
        return dv;
    endfunction

    // One clock of the reference model; called #1 after a rising edge with inputs set
    task automatic step(input bit chk);
        bit          acc;
        bit          dlv;
        logic [10:0] dcap;
        logic [14:0] flip;
        acc  = bus.in_valid && (q.size() < DEPTH);
        dlv  = bus.out_ready && (q.size() != 0);
        dcap = bus.d;
        if (chk) begin
            check("in_ready", 16'(bus.in_ready), 16'(q.size() < DEPTH));
            check("out_valid", 16'(bus.out_valid), 16'(q.size() != 0));
            check("word_count", word_count, exp_wc);
            if (q.size() != 0) begin
                check("cc", 16'(bus.cc), 16'(ref_enc(q[0])));
                if (dlv) begin
                    flip = 15'(1) << $urandom_range(0, 14);
                    check("decode", 16'(ref_dec(bus.cc)), 16'(q[0]));
                    check("decode_flip", 16'(ref_dec(bus.cc ^ flip)), 16'(q[0]));
                end
            end
        end
        @(posedge clk);
        #1;
        if (dlv) begin
            void'(q.pop_front());
            exp_wc++;
        end
        if (acc) q.push_back(dcap);
    endtask

    initial begin
        vecs[0] = '{d: 11'h000, cc: 15'h0000};
        vecs[1] = '{d: 11'h7FF, cc: 15'h7FFF};
        vecs[2] = '{d: 11'h001, cc: 15'h0007};
        vecs[3] = '{d: 11'h400, cc: 15'h408B};
        vecs[4] = '{d: 11'h002, cc: 15'h0019};
        vecs[5] = '{d: 11'h010, cc: 15'h0181};

        bus.in_valid  = 1'b0;
        bus.d         = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("rst_cc", 16'(bus.cc), 16'h0000);
        check("rst_word_count", word_count, 16'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 16'(bus.in_ready), 16'd1);

        // Constant vectors: accept, inspect head, then deliver
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.d         = vecs[i].d;
            bus.out_ready = 1'b0;
            step(1);
            bus.in_valid = 1'b0;
            check("tbl_valid", 16'(bus.out_valid), 16'd1);
            check("tbl_cc", 16'(bus.cc), 16'(vecs[i].cc));
            bus.out_ready = 1'b1;
            step(1);
            bus.out_ready = 1'b0;
            if (i == 0) check("first_delivery_count", word_count, 16'd1);
        end
        step(1);

        // Backpressure: four accepts fill the queue, the fifth word is held
        wc_base = exp_wc;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.d        = 11'(i * 97 + 5);
            step(1);
        end
        bus.d = 11'h5A5;
        check("full_in_ready", 16'(bus.in_ready), 16'd0);
        step(1);
        check("held_in_ready", 16'(bus.in_ready), 16'd0);
        bus.out_ready = 1'b1;
        step(1);
        step(1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step(1);
        check("burst_delivered", word_count, wc_base + 16'd5);
        check("burst_empty", 16'(bus.out_valid), 16'd0);

        // Steady stream at occupancy 2
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        step(1);
        step(1);
        wc_base       = exp_wc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.d = 11'($urandom);
            step(1);
        end
        check("stream_occupancy", 16'(q.size()), 16'd2);
        check("stream_deliveries", word_count, wc_base + 16'd10);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step(1);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.d         = 11'($urandom);
            step(1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= DEPTH; i++) step(1);

        // Asynchronous reset with three words queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.d = 11'($urandom);
            step(1);
        end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("async_rst_in_ready", 16'(bus.in_ready), 16'd0);
        check("async_rst_cc", 16'(bus.cc), 16'h0000);
        check("async_rst_word_count", word_count, 16'd0);
        q.delete();
        exp_wc = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rerst_in_ready", 16'(bus.in_ready), 16'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1);

        // Run the delivery counter up to its wrap point
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (exp_wc != 16'hFFFF) begin
            bus.d = 11'($urandom);
            step(0);
        end
        bus.in_valid = 1'b0;
        check("wc_max", word_count, 16'hFFFF);
        step(1);
        check("wc_wrap", word_count, 16'h0000);
        for (int i = 0; i < DEPTH && q.size() != 0; i++) step(1);
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ham_15_11_encoder_stream.md
HAM_15_11_ENCODER_STREAM -- requirements
Module: ham_15_11_encoder_stream

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of codeword entries in the output queue (power of two, >=2).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate d carries a data word.
REQ-005 in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-006 d  input  11  SHALL carry the data word; d[0] is the LSB.
REQ-007 out_valid  output  1  SHALL indicate cc carries a codeword.
REQ-008 out_ready  input  1  SHALL indicate the sink takes cc this cycle.
REQ-009 cc  output  15  SHALL carry the Hamming(15,11) codeword.
REQ-010 word_count  output  16  SHALL count codewords delivered.

Function
REQ-011 Input accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; output delivery SHALL occur with out_valid=1 and out_ready=1.
REQ-012 Codeword bit cc[k] SHALL occupy Hamming position k+1; parity at cc[0], cc[1], cc[3], cc[7]; data at cc[2], cc[4], cc[5], cc[6], cc[8]..cc[14] = d[0]..d[10] in that order.
REQ-013 Parity cc[2^j - 1] SHALL be even parity (XOR) over all data positions whose position index has bit j set, j=0..3.
REQ-014 Encoding SHALL be computed combinationally from d and written into the queue on accept; cc SHALL be driven from the queue head register.
REQ-015 Latency SHALL be one cycle: a word accepted into an empty queue SHALL appear with out_valid=1 on the following cycle.
REQ-016 Queue SHALL be FIFO ordered; an occupancy counter (0..FIFO_DEPTH) with wrapping read/write pointers.
REQ-017 in_ready SHALL equal (occupancy < FIFO_DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-018 Full: in_ready=0 even when a delivery occurs that cycle; occupancy then decrements by 1.
REQ-019 Simultaneous accept and delivery with 0 < occupancy < FIFO_DEPTH SHALL leave occupancy unchanged and advance both pointers.
REQ-020 Empty: out_valid=0; cc SHALL hold its last value (don't-care for checking).
REQ-021 out_valid SHALL equal (occupancy != 0); while out_valid=1 and out_ready=0, cc SHALL remain stable.
REQ-022 word_count SHALL increment by 1 per delivery, wrapping 16'hFFFF -> 16'h0000 without flag.
REQ-023 Accept with in_valid=1 while in_ready=0 SHALL have no effect; the source must hold d.

Reset
REQ-024 rst=1 SHALL immediately clear occupancy, pointers, word_count; out_valid=0, in_ready=0 while rst=1, cc=15'h0000.
REQ-025 Reset mid-operation SHALL discard all queued codewords; in_ready=1 on the first clock edge after rst deasserts.

Verification
REQ-026 d=11'h000 accepted, out_ready=1 -> next cycle out_valid=1, cc=15'h0000, word_count 0->1 after delivery.
REQ-027 d=11'h7FF -> cc=15'h7FFF; d=11'h001 -> cc=15'h0007; d=11'h400 -> cc=15'h408B.
REQ-028 out_ready=0, push 5 words with FIFO_DEPTH=4 -> in_ready drops after 4th accept, 5th held; release out_ready -> 5 codewords delivered in order, word_count=5.
REQ-029 Occupancy 2, in_valid=1 and out_ready=1 for 10 cycles -> occupancy stays 2, 10 deliveries in order.
REQ-030 Preload word_count to 16'hFFFF via 65535 deliveries, one more -> word_count=16'h0000.
REQ-031 rst asserted with 3 words queued -> out_valid=0 asynchronously; after release no stale codeword emitted, word_count=0.
REQ-032 Random 11-bit d stream vs. paired ham_15_11_decoder: decoded q SHALL equal d for every word, and single-bit flips of cc SHALL decode to d.
